// File: rtl/act_dispatch.sv
// act_dispatch: stages row-interleaved activation words in a small FIFO and
// issues them in strict row order to N_ROW sblk rows under per-row requests.
// Optional stall counter: define ACT_DISPATCH_PERF_EN to build it; otherwise
// perf_stall_cnt is tied to zero.
module act_dispatch #(
    parameter int unsigned N_ROW      = 8,
    parameter int unsigned WID_ACT    = 16,
    parameter int unsigned FIFO_DEPTH = 4,
    parameter int unsigned WID_LEN    = 16
) (
    input  logic                           clk_l,
    input  logic                           rst,
    input  logic                           start,
    input  logic [WID_LEN-1:0]             cfg_len,
    output logic                           busy,
    output logic                           done,
    input  logic [2*WID_ACT-1:0]           act_in,
    input  logic                           act_in_vld,
    output logic                           act_in_rdy,
    output logic [2*WID_ACT*N_ROW-1:0]     act_data_in,
    output logic [N_ROW-1:0]               act_data_in_vld,
    input  logic [N_ROW-1:0]               act_data_in_req,
    output logic [31:0]                    perf_stall_cnt
);

    localparam int unsigned WORD_W = 2 * WID_ACT;
    localparam int unsigned ROW_W  = (N_ROW > 1) ? $clog2(N_ROW) : 1;
    localparam int unsigned TOT_W  = WID_LEN + $clog2(N_ROW);
    localparam int unsigned PTR_W  = $clog2(FIFO_DEPTH);
    localparam int unsigned CNT_W  = PTR_W + 1;

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;

    state_e                    state_q, state_d;
    logic [TOT_W-1:0]          total_q, total_d;
    logic [TOT_W-1:0]          acc_q, acc_d;
    logic [TOT_W-1:0]          iss_q, iss_d;
    logic [ROW_W-1:0]          row_ptr_q, row_ptr_d;
    logic [CNT_W-1:0]          wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]          rd_ptr_q, rd_ptr_d;
    logic [WORD_W-1:0]         mem_q [FIFO_DEPTH];
    logic [WORD_W*N_ROW-1:0]   data_q, data_d;
    logic [N_ROW-1:0]          vld_q, vld_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;

    logic [CNT_W-1:0]          fifo_cnt;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      push;
    logic                      pop;
    logic                      job_start;
    logic [WORD_W-1:0]         head;

    // FIFO status, upstream handshake and issue decision
    always_comb begin
        fifo_cnt   = wr_ptr_q - rd_ptr_q;
        fifo_full  = (fifo_cnt == CNT_W'(FIFO_DEPTH));
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        act_in_rdy = !rst && (state_q == S_RUN) && !fifo_full && (acc_q < total_q);
        push       = act_in_vld && act_in_rdy;
        pop        = (state_q == S_RUN) && !fifo_empty && act_data_in_req[row_ptr_q];
        job_start  = (state_q == S_IDLE) && start && (cfg_len != '0);
        head       = mem_q[rd_ptr_q[PTR_W-1:0]];
    end

    // Next-state: FSM, job counters, FIFO pointers and registered row outputs
    always_comb begin
        state_d   = state_q;
        total_d   = total_q;
        acc_d     = acc_q;
        iss_d     = iss_q;
        row_ptr_d = row_ptr_q;
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        data_d    = data_q;
        vld_d     = '0;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    if (cfg_len == '0) begin
                        state_d = S_DONE;
                    end else begin
                        state_d   = S_RUN;
                        total_d   = TOT_W'(cfg_len) * TOT_W'(N_ROW);
                        acc_d     = '0;
                        iss_d     = '0;
                        row_ptr_d = '0;
                        wr_ptr_d  = '0;
                        rd_ptr_d  = '0;
                    end
                end
            end
            S_RUN: begin
                if (push) begin
                    wr_ptr_d = wr_ptr_q + CNT_W'(1);
                    acc_d    = acc_q + TOT_W'(1);
                end
                if (pop) begin
                    rd_ptr_d  = rd_ptr_q + CNT_W'(1);
                    iss_d     = iss_q + TOT_W'(1);
                    row_ptr_d = (row_ptr_q == ROW_W'(N_ROW - 1)) ? '0 : row_ptr_q + ROW_W'(1);
                    for (int r = 0; r < N_ROW; r++) begin
                        if (row_ptr_q == ROW_W'(r)) begin
                            data_d[r*WORD_W +: WORD_W] = head;
                            vld_d[r]                   = 1'b1;
                        end
                    end
                    if (iss_q + TOT_W'(1) == total_q) state_d = S_DONE;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
        busy_d = (state_d != S_IDLE);
        done_d = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge clk_l) begin
        if (rst) begin
            state_q   <= S_IDLE;
            total_q   <= '0;
            acc_q     <= '0;
            iss_q     <= '0;
            row_ptr_q <= '0;
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            data_q    <= '0;
            vld_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            total_q   <= total_d;
            acc_q     <= acc_d;
            iss_q     <= iss_d;
            row_ptr_q <= row_ptr_d;
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            data_q    <= data_d;
            vld_q     <= vld_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    // FIFO storage; contents need no reset since pointers define validity
    always_ff @(posedge clk_l) begin
        if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= act_in;
    end

    assign act_data_in     = data_q;
    assign act_data_in_vld = vld_q;
    assign busy            = busy_q;
    assign done            = done_q;

`ifdef ACT_DISPATCH_PERF_EN
    logic [31:0] perf_q, perf_d;

    // Saturating count of RUN cycles stalled on the current row's request
    always_comb begin
        perf_d = perf_q;
        if (job_start) begin
            perf_d = '0;
        end else if ((state_q == S_RUN) && !fifo_empty && !act_data_in_req[row_ptr_q]
                     && (perf_q != 32'hFFFF_FFFF)) begin
            perf_d = perf_q + 32'd1;
        end
    end

    // Stall counter register
    always_ff @(posedge clk_l) begin
        if (rst) perf_q <= '0;
        else     perf_q <= perf_d;
    end

    assign perf_stall_cnt = perf_q;
`else
    assign perf_stall_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_act_dispatch.sv
// Self-checking bench for act_dispatch: directed scenarios plus randomized
// jobs, compared every cycle against a queue-based reference model.
module tb_act_dispatch;

    localparam int unsigned N_ROW      = 8;
    localparam int unsigned WID_ACT    = 16;
    localparam int unsigned FIFO_DEPTH = 4;
    localparam int unsigned WID_LEN    = 16;
    localparam int unsigned WORD_W     = 2 * WID_ACT;

    logic                        clk_l = 1'b0;
    logic                        rst;
    logic                        start;
    logic [WID_LEN-1:0]          cfg_len;
    logic                        busy;
    logic                        done;
    logic [WORD_W-1:0]           act_in;
    logic                        act_in_vld;
    logic                        act_in_rdy;
    logic [WORD_W*N_ROW-1:0]     act_data_in;
    logic [N_ROW-1:0]            act_data_in_vld;
    logic [N_ROW-1:0]            act_data_in_req;
    logic [31:0]                 perf_stall_cnt;

    act_dispatch #(
        .N_ROW(N_ROW), .WID_ACT(WID_ACT), .FIFO_DEPTH(FIFO_DEPTH), .WID_LEN(WID_LEN)
    ) dut (
        .clk_l(clk_l), .rst(rst), .start(start), .cfg_len(cfg_len),
        .busy(busy), .done(done),
        .act_in(act_in), .act_in_vld(act_in_vld), .act_in_rdy(act_in_rdy),
        .act_data_in(act_data_in), .act_data_in_vld(act_data_in_vld),
        .act_data_in_req(act_data_in_req), .perf_stall_cnt(perf_stall_cnt)
    );

    always #5 clk_l = ~clk_l;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: job phase (0 idle, 1 run, 2 done) and a word queue
    int                 m_phase = 0;
    int unsigned        m_total = 0;
    int unsigned        m_acc   = 0;
    int unsigned        m_iss   = 0;
    int unsigned        m_ptr   = 0;
    logic [WORD_W-1:0]  m_q[$];
    logic [WORD_W-1:0]  m_data [N_ROW];
    logic [N_ROW-1:0]   m_vld   = '0;
    logic [31:0]        m_stall = '0;

    bit                 last_push;
    int                 n_hs;
    int                 n_vld;
    logic [WORD_W-1:0]  word;

    task automatic check_eq(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
        end
    endtask

    // One clock: check combinational ready, advance model, check registered outputs
    task automatic step();
        logic                    exp_rdy;
        logic                    pop;
        logic                    stall;
        logic [WORD_W*N_ROW-1:0] exp_bus;
        #1;
        exp_rdy = !rst && (m_phase == 1) && (m_q.size() < FIFO_DEPTH) && (m_acc < m_total);
        check_eq("act_in_rdy", 256'(act_in_rdy), 256'(exp_rdy));
        last_push = act_in_vld && exp_rdy;
        if (act_in_vld && act_in_rdy) n_hs++;
        m_vld = '0;
        if (rst) begin
            m_phase = 0;
            m_q.delete();
            for (int r = 0; r < N_ROW; r++) m_data[r] = '0;
            m_stall = '0;
            m_acc = 0; m_iss = 0; m_ptr = 0; m_total = 0;
        end else begin
            case (m_phase)
                0: if (start) begin
                    if (cfg_len == 0) m_phase = 2;
                    else begin
                        m_phase = 1;
                        m_total = cfg_len * N_ROW;
                        m_acc = 0; m_iss = 0; m_ptr = 0;
                        m_stall = '0;
                        m_q.delete();
                    end
                end
                1: begin
                    stall = (m_q.size() > 0) && !act_data_in_req[m_ptr];
                    pop   = (m_q.size() > 0) &&  act_data_in_req[m_ptr];
                    if (pop) begin
                        m_data[m_ptr] = m_q.pop_front();
                        m_vld[m_ptr]  = 1'b1;
                        m_iss++;
                        m_ptr = (m_ptr + 1) % N_ROW;
                        if (m_iss == m_total) m_phase = 2;
                    end
                    if (last_push) begin
                        m_q.push_back(act_in);
                        m_acc++;
                    end
                    if (stall && m_stall != 32'hFFFF_FFFF) m_stall++;
                end
                default: m_phase = 0;
            endcase
        end
        @(posedge clk_l);
        #1;
        for (int r = 0; r < N_ROW; r++) exp_bus[r*WORD_W +: WORD_W] = m_data[r];
        check_eq("busy", 256'(busy), 256'(m_phase != 0));
        check_eq("done", 256'(done), 256'(m_phase == 2));
        check_eq("vld", 256'(act_data_in_vld), 256'(m_vld));
        check_eq("data", 256'(act_data_in), 256'(exp_bus));
`ifdef ACT_DISPATCH_PERF_EN
        check_eq("perf", 256'(perf_stall_cnt), 256'(m_stall));
`else
        check_eq("perf", 256'(perf_stall_cnt), 256'(0));
`endif
        if (act_data_in_vld != '0) n_vld++;
        @(negedge clk_l);
    endtask

    task automatic start_job(input int unsigned len);
        start   = 1'b1;
        cfg_len = WID_LEN'(len);
        step();
        start   = 1'b0;
    endtask

    // Drive a job to completion; mode 0 all req/vld high, 1 random, 2 hold req[3] for 10 stalls
    task automatic run_job(input int mode);
        int guard = 0;
        while (m_phase != 0 && guard < 400) begin
            act_in = word;
            case (mode)
                0: begin act_in_vld = 1'b1; act_data_in_req = '1; end
                1: begin
                    act_in_vld      = ($urandom_range(0, 3) != 0);
                    act_data_in_req = N_ROW'($urandom) | N_ROW'($urandom);
                    start           = ($urandom_range(0, 7) == 0);
                    cfg_len         = WID_LEN'($urandom);
                end
                default: begin
                    act_in_vld      = 1'b1;
                    act_data_in_req = (m_stall < 10) ? 8'hF7 : 8'hFF;
                end
            endcase
            step();
            if (last_push) word++;
            guard++;
        end
        start = 1'b0;
        if (guard >= 400) check_eq("job_timeout", 256'(1), 256'(0));
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; cfg_len = '0; act_in = '0; act_in_vld = 1'b0;
        act_data_in_req = '1;
        for (int r = 0; r < N_ROW; r++) m_data[r] = '0;
        @(negedge clk_l);
        step();
        step();
        rst = 1'b0;
        step();

        // 16 words to 8 rows, two passes, done with the final vld
        word = 32'h1; n_vld = 0;
        start_job(2);
        run_job(0);
        check_eq("s1_vld_count", 256'(n_vld), 256'(16));

        // zero-length job: done next cycle, no ready, no vld
        n_vld = 0;
        act_in_vld = 1'b1;
        start_job(0);
        step();
        act_in_vld = 1'b0;
        check_eq("s2_vld_count", 256'(n_vld), 256'(0));

        // row 3 stalls for 10 cycles with the FIFO backed up
        word = 32'h100;
        start_job(1);
        run_job(2);
`ifdef ACT_DISPATCH_PERF_EN
        check_eq("s3_perf", 256'(perf_stall_cnt), 256'(10));
`else
        check_eq("s3_perf", 256'(perf_stall_cnt), 256'(0));
`endif

        // upstream over-offers: exactly the job total is accepted
        word = 32'h200; n_hs = 0;
        start_job(2);
        run_job(0);
        for (int i = 0; i < 4; i++) begin act_in_vld = 1'b1; step(); end
        act_in_vld = 1'b0;
        check_eq("s4_accepted", 256'(n_hs), 256'(16));

        // reset mid-job after 5 issues, then a fresh job from row 0
        word = 32'h300;
        start_job(2);
        begin
            int guard = 0;
            while (m_iss < 5 && guard < 100) begin
                act_in = word; act_in_vld = 1'b1; act_data_in_req = '1;
                step();
                if (last_push) word++;
                guard++;
            end
            if (guard >= 100) check_eq("s5_timeout", 256'(1), 256'(0));
        end
        rst = 1'b1; act_in_vld = 1'b0;
        step();
        rst = 1'b0;
        step();
        word = 32'h400; n_vld = 0;
        start_job(1);
        run_job(0);
        check_eq("s5_vld_count", 256'(n_vld), 256'(8));

        // start/cfg_len noise during RUN must not disturb the job
        word = 32'h500;
        start_job(2);
        for (int i = 0; i < 6; i++) begin
            start = 1'b1; cfg_len = WID_LEN'(7); act_in = word; act_in_vld = 1'b1;
            step();
            if (last_push) word++;
        end
        start = 1'b0;
        run_job(0);

        // randomized jobs with random requests, valids and start noise
        for (int j = 0; j < 8; j++) begin
            word = WORD_W'($urandom);
            start_job($urandom_range(1, 3));
            run_job(1);
            step();
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/act_dispatch.md
ACT_DISPATCH -- requirements
Module: act_dispatch

Interface
- REQ-001: Parameter N_ROW, default 8: number of sblk rows fed by this block.
- REQ-002: Parameter WID_ACT, default 16: activation half-word width; one transfer word is 2*WID_ACT bits.
- REQ-003: Parameter FIFO_DEPTH, default 4: staging FIFO depth in words (power of 2, >=2).
- REQ-004: Parameter WID_LEN, default 16: width of the per-row word-count field.
- REQ-005: clk_l  in  1: single clock; all logic SHALL be on rising edge.
- REQ-006: rst  in  1: reset, synchronous, active-high.
- REQ-007: start  in  1: job start pulse, honoured only in IDLE.
- REQ-008: cfg_len  in  WID_LEN: words per row for the job, sampled with start.
- REQ-009: busy  out  1: high whenever the FSM is not IDLE.
- REQ-010: done  out  1: one-cycle job-complete pulse.
- REQ-011: act_in  in  2*WID_ACT: upstream word, row-interleaved order (row 0, 1, ..., N_ROW-1, row 0, ...).
- REQ-012: act_in_vld  in  1 / act_in_rdy  out  1: upstream valid/ready; a word transfers when both are high.
- REQ-013: act_data_in  out  2*WID_ACT*N_ROW: per-row data; row r occupies bits [r*2*WID_ACT +: 2*WID_ACT].
- REQ-014: act_data_in_vld  out  N_ROW: per-row one-cycle data strobe.
- REQ-015: act_data_in_req  in  N_ROW: per-row level request from sblk; high means the row accepts data.
- REQ-016: perf_stall_cnt  out  32: stall counter (see Configuration).

Function
- REQ-017: FSM states SHALL be IDLE, RUN, DONE; transitions IDLE->RUN on start with cfg_len!=0; IDLE->DONE on start with cfg_len==0; RUN->DONE when issued count equals cfg_len*N_ROW; DONE->IDLE after exactly one cycle.
- REQ-018: done SHALL be high exactly in the DONE cycle; start outside IDLE SHALL be ignored.
- REQ-019: On RUN entry, the job total (cfg_len*N_ROW, width WID_LEN+clog2(N_ROW)), accepted count, issued count and row_ptr SHALL be cleared/latched; row_ptr starts at 0.
- REQ-020: act_in_rdy SHALL be combinational: high only in RUN, with FIFO not full, and accepted count < job total; no words are accepted beyond the total.
- REQ-021: A full FIFO SHALL deassert act_in_rdy even if a pop occurs in the same cycle (no pass-through).
- REQ-022: Issue at cycle t: in RUN, FIFO non-empty and act_data_in_req[row_ptr] sampled high -> pop head, increment issued count, advance row_ptr (wrap N_ROW-1 -> 0).
- REQ-023: Outputs SHALL be registered: an issue at t drives act_data_in_vld[row_ptr]=1 and the popped word on that row's slice at t+1, for one cycle.
- REQ-024: Row slices not being issued to SHALL hold their last value; at most one vld bit is high per cycle.
- REQ-025: Delivery SHALL be strictly in order; if req[row_ptr] is low, the block stalls (no skipping to other rows).
- REQ-026: A row SHALL tolerate one word arriving the cycle after it deasserts req (one-cycle registered latency).
- REQ-027: The last issue at t SHALL place the FSM in DONE at t+1, so done coincides with the final vld.
- REQ-028: Simultaneous push and pop SHALL be permitted when the FIFO is neither full nor empty; occupancy is unchanged.

Reset
- REQ-029: rst high SHALL, at the next edge, force IDLE, empty the FIFO, clear counters and row_ptr, and drive busy=0, done=0, act_data_in=0, act_data_in_vld=0, perf_stall_cnt=0.
- REQ-030: rst during RUN SHALL abandon the job without a done pulse; act_in_rdy is 0 while rst is high and in the cycle following reset.

Configuration
- REQ-031: Macro ACT_DISPATCH_PERF_EN defined: perf_stall_cnt increments each RUN cycle with FIFO non-empty and act_data_in_req[row_ptr] low, clears on RUN entry, saturates at 2^32-1, and holds after the job.
- REQ-032: ACT_DISPATCH_PERF_EN undefined: perf_stall_cnt SHALL be constant 0 with no counter logic.

Verification
- REQ-033: N_ROW=8, cfg_len=2, all req high, act_in_vld high with 16 words 0x1..0x10 -> rows 0..7 receive 0x1..0x8 then 0x9..0x10, one vld per cycle, done with the 16th vld.
- REQ-034: start with cfg_len=0 -> done pulses the next cycle, no act_in_rdy, no vld.
- REQ-035: cfg_len=1, req[3] held low for 10 cycles -> rows 0..2 served, FIFO fills to 4, act_in_rdy drops, no row 4+ vld until req[3] rises; perf_stall_cnt=10 with ACT_DISPATCH_PERF_EN, else 0.
- REQ-036: Upstream offers 20 words for a cfg_len=2 job -> exactly 16 accepted; act_in_rdy low after the 16th.
- REQ-037: rst pulsed mid-job after 5 issues -> vld/busy low next cycle, no done; a new start with cfg_len=1 delivers 8 fresh words starting at row 0.
- REQ-038: start asserted during RUN -> ignored; cfg_len change has no effect on the running job.
